// File: rtl/relay_coil_driver.sv
// relay_coil_driver
//   Coil-drive sequencer for the relay switch macro. A level request is turned
//   into full-on pull-in, then reduced-duty PWM hold, then a guarded release
//   with a minimum coil-off time.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   level request, 1 = relay closed requested
//   force_off  in   immediate release, overrides req in every state
//   coil_drv   out  registered coil control (1 = energise)
//   closed     out  registered, contact considered closed (HOLD)
//   busy       out  registered, 1 in PULLIN or RELEASE
//   fault      out  registered sticky watchdog trip
//
// Configuration macro
//   RELAY_DRV_WDOG_EN  enables the HOLD-duration watchdog; when undefined,
//                      fault is tied to 0 and HOLD is unbounded.

module relay_coil_driver #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned PULLIN_CYC   = 100,
  parameter int unsigned HOLD_PERIOD  = 10,
  parameter int unsigned HOLD_DUTY    = 4,
  parameter int unsigned RELEASE_CYC  = 50,
  parameter int unsigned MAX_HOLD_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic force_off,
  output logic coil_drv,
  output logic closed,
  output logic busy,
  output logic fault
);

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_PULLIN  = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  // Zero-length phases behave as one cycle
  localparam int unsigned PULLIN_EFF  = (PULLIN_CYC   == 0) ? 1 : PULLIN_CYC;
  localparam int unsigned RELEASE_EFF = (RELEASE_CYC  == 0) ? 1 : RELEASE_CYC;
  localparam int unsigned PERIOD_EFF  = (HOLD_PERIOD  == 0) ? 1 : HOLD_PERIOD;
  localparam int unsigned WDOG_EFF    = (MAX_HOLD_CYC == 0) ? 1 : MAX_HOLD_CYC;

  // Terminal counts: a phase of N cycles ends when its counter shows N-1
  localparam logic [CNT_W-1:0] PULLIN_LAST  = CNT_W'(PULLIN_EFF - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_EFF - 1);
  localparam logic [CNT_W-1:0] PWM_LAST     = CNT_W'(PERIOD_EFF - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST    = CNT_W'(WDOG_EFF - 1);
  localparam logic [CNT_W-1:0] DUTY         = CNT_W'(HOLD_DUTY);
  localparam logic             HOLD_ON0     = (HOLD_DUTY != 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] pwm_q;
  logic             coil_q;
  logic             closed_q;
  logic             busy_q;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] pwm_nxt;
  logic             release_req;
  logic             fault_blk;
  logic             wdog_trip;

  // Saturating phase counter and wrapping PWM counter
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign pwm_nxt     = (pwm_q >= PWM_LAST) ? '0 : pwm_q + CNT_W'(1);
  assign release_req = force_off | ~req;

`ifdef RELAY_DRV_WDOG_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             fault_q;

  assign fault_blk = fault_q;
  assign wdog_trip = (hold_cnt_q >= WDOG_LAST);
  assign fault     = fault_q;

  // Watchdog: counts HOLD cycles, trips sticky fault, clears in OFF with req=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          hold_cnt_q <= '0;
          if (!req) fault_q <= 1'b0;
        end
        S_HOLD: begin
          if (!release_req && wdog_trip) fault_q <= 1'b1;
          if (hold_cnt_q != {CNT_W{1'b1}}) hold_cnt_q <= hold_cnt_q + CNT_W'(1);
        end
        default: hold_cnt_q <= '0;
      endcase
    end
  end
`else
  assign fault_blk = 1'b0;
  assign wdog_trip = 1'b0;
  assign fault     = 1'b0;

  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_LAST;
`endif

  // Sequencer: state, phase counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      pwm_q    <= '0;
      coil_q   <= 1'b0;
      closed_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (req && !force_off && !fault_blk) begin
            state_q  <= S_PULLIN;
            cnt_q    <= '0;
            coil_q   <= 1'b1;
            busy_q   <= 1'b1;
            closed_q <= 1'b0;
          end
        end

        S_PULLIN: begin
          // Release request wins over pull-in expiry
          if (release_req) begin
            state_q  <= S_RELEASE;
            cnt_q    <= '0;
            coil_q   <= 1'b0;
            closed_q <= 1'b0;
            busy_q   <= 1'b1;
          end else if (cnt_q >= PULLIN_LAST) begin
            state_q  <= S_HOLD;
            pwm_q    <= '0;
            coil_q   <= HOLD_ON0;
            closed_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        S_HOLD: begin
          if (release_req || wdog_trip) begin
            state_q  <= S_RELEASE;
            cnt_q    <= '0;
            coil_q   <= 1'b0;
            closed_q <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            pwm_q  <= pwm_nxt;
            coil_q <= (pwm_nxt < DUTY);
          end
        end

        S_RELEASE: begin
          // Inputs ignored until the minimum off time has elapsed
          if (cnt_q >= RELEASE_LAST) begin
            state_q <= S_OFF;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        default: begin
          state_q  <= S_OFF;
          coil_q   <= 1'b0;
          closed_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign coil_drv = coil_q;
  assign closed   = closed_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_relay_coil_driver.sv
// Directed bench for relay_coil_driver: default instance for sequencing,
// plus two small instances for the PWM duty extremes and zero-length phases.
module tb_relay_coil_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic req;
  logic force_off;
  logic req_b;
  logic coil_drv, closed, busy, fault;
  logic f_coil, f_closed, f_busy, f_fault;
  logic z_coil, z_closed, z_busy, z_fault;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  relay_coil_driver u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .force_off(force_off),
    .coil_drv(coil_drv), .closed(closed), .busy(busy), .fault(fault)
  );

  relay_coil_driver #(
    .PULLIN_CYC(3), .HOLD_PERIOD(10), .HOLD_DUTY(10), .RELEASE_CYC(2)
  ) u_full (
    .clk(clk), .rst_n(rst_n), .req(req_b), .force_off(1'b0),
    .coil_drv(f_coil), .closed(f_closed), .busy(f_busy), .fault(f_fault)
  );

  relay_coil_driver #(
    .PULLIN_CYC(0), .HOLD_PERIOD(10), .HOLD_DUTY(0), .RELEASE_CYC(0)
  ) u_zero (
    .clk(clk), .rst_n(rst_n), .req(req_b), .force_off(1'b0),
    .coil_drv(z_coil), .closed(z_closed), .busy(z_busy), .fault(z_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_main(input string tag, input logic c, input logic cl, input logic b);
    chk({tag, ".coil"},   32'(coil_drv), 32'(c));
    chk({tag, ".closed"}, 32'(closed),   32'(cl));
    chk({tag, ".busy"},   32'(busy),     32'(b));
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 1'b0;
    force_off = 1'b0;
    req_b     = 1'b0;

    // Reset state
    tick(3);
    chk_main("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.fault", 32'(fault), 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk_main("idle", 1'b0, 1'b0, 1'b0);

    // Close / open: req set after edge 0
    req = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk_main($sformatf("pullin%0d", k), 1'b1, 1'b0, 1'b1);
    end
    for (int j = 0; j < 30; j++) begin
      tick();
      chk_main($sformatf("hold%0d", j), ((j % 10) < 4), 1'b1, 1'b0);
    end
    req = 1'b0;
    for (int r = 0; r < 50; r++) begin
      tick();
      chk_main($sformatf("rel%0d", r), 1'b0, 1'b0, 1'b1);
    end
    tick();
    chk_main("off_after_rel", 1'b0, 1'b0, 1'b0);

    // Abort in pull-in at cycle 40
    req = 1'b1;
    tick(40);
    chk_main("abort.pullin", 1'b1, 1'b0, 1'b1);
    req = 1'b0;
    for (int r = 0; r < 50; r++) begin
      tick();
      chk_main($sformatf("abort.rel%0d", r), 1'b0, 1'b0, 1'b1);
    end
    tick();
    chk_main("abort.off", 1'b0, 1'b0, 1'b0);

    // force_off in HOLD with req held high, then automatic re-pull-in
    req = 1'b1;
    tick(101);
    chk_main("fo.hold", 1'b1, 1'b1, 1'b0);
    tick(5);
    force_off = 1'b1;
    tick();
    chk_main("fo.rel", 1'b0, 1'b0, 1'b1);
    tick();
    force_off = 1'b0;
    tick(48);
    chk_main("fo.rel_end", 1'b0, 1'b0, 1'b1);
    tick();
    chk_main("fo.off", 1'b0, 1'b0, 1'b0);
    tick();
    chk_main("fo.repull", 1'b1, 1'b0, 1'b1);

    // force_off blocks PULLIN from OFF
    req = 1'b0;
    tick(51);
    chk_main("fo.back_off", 1'b0, 1'b0, 1'b0);
    req       = 1'b1;
    force_off = 1'b1;
    tick(2);
    chk_main("fo.blocked", 1'b0, 1'b0, 1'b0);
    force_off = 1'b0;
    tick();
    chk_main("fo.unblocked", 1'b1, 1'b0, 1'b1);
    req = 1'b0;
    tick(51);
    chk_main("fo.idle", 1'b0, 1'b0, 1'b0);

    // PWM extremes and zero-length phases
    req_b = 1'b1;
    tick();
    chk("full.pullin.coil", 32'(f_coil), 32'd1);
    chk("zero.pullin.coil", 32'(z_coil), 32'd1);
    chk("zero.pullin.busy", 32'(z_busy), 32'd1);
    tick();
    chk("zero.hold.closed", 32'(z_closed), 32'd1);
    chk("zero.hold.coil",   32'(z_coil),   32'd0);
    chk("zero.hold.busy",   32'(z_busy),   32'd0);
    chk("full.pull2.busy",  32'(f_busy),   32'd1);
    tick(2);
    for (int j = 0; j < 20; j++) begin
      chk($sformatf("full.hold%0d.coil", j),   32'(f_coil),   32'd1);
      chk($sformatf("full.hold%0d.closed", j), 32'(f_closed), 32'd1);
      chk($sformatf("zero.hold%0d.coil", j),   32'(z_coil),   32'd0);
      chk($sformatf("zero.hold%0d.closed", j), 32'(z_closed), 32'd1);
      tick();
    end
    req_b = 1'b0;
    tick();
    chk("full.rel.busy", 32'(f_busy), 32'd1);
    chk("zero.rel.busy", 32'(z_busy), 32'd1);
    chk("zero.rel.coil", 32'(z_coil), 32'd0);
    tick();
    chk("zero.off.busy", 32'(z_busy), 32'd0);
    chk("full.rel2.busy", 32'(f_busy), 32'd1);
    tick();
    chk("full.off.busy", 32'(f_busy), 32'd0);
    chk("full.fault", 32'(f_fault), 32'd0);
    chk("zero.fault", 32'(z_fault), 32'd0);

    // Long HOLD: watchdog behaviour or unbounded hold
    req = 1'b1;
    tick(101);
    chk_main("wd.hold_entry", 1'b1, 1'b1, 1'b0);
`ifdef RELAY_DRV_WDOG_EN
    tick(999);
    chk_main("wd.hold_last", ((999 % 10) < 4), 1'b1, 1'b0);
    chk("wd.fault_pre", 32'(fault), 32'd0);
    tick();
    chk_main("wd.trip", 1'b0, 1'b0, 1'b1);
    chk("wd.fault", 32'(fault), 32'd1);
    tick(50);
    chk_main("wd.off", 1'b0, 1'b0, 1'b0);
    tick(3);
    chk_main("wd.blocked", 1'b0, 1'b0, 1'b0);
    chk("wd.sticky", 32'(fault), 32'd1);
    req = 1'b0;
    tick();
    chk("wd.clear", 32'(fault), 32'd0);
`else
    for (int m = 1; m <= 5; m++) begin
      tick(1000);
      chk_main($sformatf("hold_long%0d", m), (((1000 * m) % 10) < 4), 1'b1, 1'b0);
      chk($sformatf("hold_long%0d.fault", m), 32'(fault), 32'd0);
    end
    req = 1'b0;
    tick(51);
    chk_main("long.off", 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-PULLIN
    req = 1'b1;
    tick(11);
    chk_main("rst.pullin", 1'b1, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_main("rst.async", 1'b0, 1'b0, 1'b0);
    chk("rst.fault", 32'(fault), 32'd0);
    req = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk_main("rst.off", 1'b0, 1'b0, 1'b0);
    req = 1'b1;
    tick();
    chk_main("rst.restart", 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
